sd_sector_arbiter: RTL and testbench
====================================

// Module: sd_sector_arbiter
// PURPOSE
//  Shares one sd_reader sector-read engine between two requesters (port 0: boot image loader,
//  port 1: runtime block-device path). Round-robin arbitration, drives rstart/rsector, routes the
//  512-byte outen/outbyte stream to the owner, enforces a per-sector timeout with bounded retry.
//  Sits between the requesters and sd_reader, in the clk27mhz domain.
// PARAMETERS
//  SECTOR_BYTES  512       bytes expected per sector read
//  TIMEOUT_CYC   2_700_000 cycles allowed from rd_start rise to rd_done (100 ms @ 27 MHz)
//  MAX_RETRY     2         re-issues after a timeout or short read before reporting error
// PORTS
//  clk27mhz     in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  card_ready   in   1   sd_reader initialisation complete; no grant while low
//  reqN_valid   in   1   (N=0,1) sector read request, held until reqN_ack
//  reqN_sector  in   32  sector number, stable while reqN_valid
//  reqN_ack     out  1   1-cycle pulse: request accepted (grant)
//  reqN_done    out  1   1-cycle pulse: sector delivered OK
//  reqN_err     out  1   1-cycle pulse: sector failed after MAX_RETRY retries
//  rd_start     out  1   to sd_reader rstart; level, held until rd_done or timeout
//  rd_sector    out  32  to sd_reader rsector; stable while rd_start high
//  rd_done      in   1   from sd_reader; 1-cycle pulse at end of sector
//  rd_outen     in   1   from sd_reader; byte strobe
//  rd_outbyte   in   8   from sd_reader; byte data
//  dat_valid    out  1   registered copy of rd_outen while a read is owned, else 0
//  dat_byte     out  8   registered copy of rd_outbyte
//  dat_owner    out  1   requester owning current/last transfer (0/1)
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last_grant=1 (port 0 wins first tie), counters 0.
//  FSM: IDLE -> ISSUE -> WAIT -> (DONE | RETRY | FAIL) -> IDLE.
//  IDLE: if card_ready and any reqN_valid, grant. Both valid: grant !last_grant. One valid: grant it.
//   Grant cycle: reqN_ack=1, latch sector to rd_sector, owner<=N, last_grant<=N, retry_cnt<=0,
//   byte_cnt<=0 -> ISSUE. card_ready low: stay IDLE, no ack.
//  ISSUE: rd_start<=1, tmo_cnt<=0 -> WAIT (rd_start rises 1 cycle after ack).
//  WAIT: rd_start held. Each rd_outen: byte_cnt++ (saturating at SECTOR_BYTES), dat_valid=1
//   next cycle with dat_byte. Bytes beyond SECTOR_BYTES are dropped (dat_valid stays 0).
//   rd_done: rd_start<=0; byte_cnt==SECTOR_BYTES (counting a same-cycle outen) -> DONE, else RETRY.
//   tmo_cnt==TIMEOUT_CYC-1 without rd_done: rd_start<=0 -> RETRY. rd_done wins over same-cycle timeout.
//  RETRY: retry_cnt<MAX_RETRY: retry_cnt++, byte_cnt<=0 -> ISSUE (rd_start low >=1 cycle
//   between attempts). Else -> FAIL.
//  DONE: reqN_done pulse for owner -> IDLE. FAIL: reqN_err pulse for owner -> IDLE.
//  Total attempts per request = 1+MAX_RETRY. Worst-case latency ack->err =
//   (1+MAX_RETRY)*(TIMEOUT_CYC+2)+1 cycles. Min gap done->next ack = 1 cycle (IDLE).
//  rd_done/rd_outen while IDLE: ignored, no dat_valid. reqN_valid dropping after ack: ignored.
//  tmo_cnt width = $clog2(TIMEOUT_CYC)+1; byte_cnt width = $clog2(SECTOR_BYTES)+1.
//  Reset asserted mid-transfer: immediate return to reset values; rd_start drops asynchronously.
// TESTING
//  T1 req0 only, sector 5, model returns 512 bytes then rd_done -> ack0, rd_sector=5, 512
//     dat_valid pulses with owner 0, single done0; rd_start low after rd_done.
//  T2 req0,req1 asserted same cycle from reset -> port 0 served first, then port 1; repeat
//     -> alternates 0,1,0,1 (round-robin).
//  T3 model never pulses rd_done, TIMEOUT_CYC=100, MAX_RETRY=2 -> three rd_start pulses each
//     100 cycles, each separated by a low cycle, then err1 pulse, no done1.
//  T4 short read (300 bytes + rd_done) on first attempt, full 512 on second -> one retry,
//     done0, no err0.
//  T5 card_ready low with req1_valid -> no ack; raise card_ready -> ack1 next cycle.
//  T6 reset pulse during WAIT after 100 bytes -> rd_start, busy, dat_valid 0 immediately;
//     after release, new request completes normally with byte_cnt starting at 0.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
//   Shares one sd_reader sector-read engine between two requesters
//   (port 0: boot image loader, port 1: runtime block-device path).
//   Round-robin grant, drives rd_start/rd_sector, forwards the byte stream
//   to the owner, and applies a per-attempt timeout with bounded retry.
//
// Ports
//   clk27mhz, reset          clock, asynchronous active-high reset
//   card_ready               sd_reader initialised; no grant while low
//   reqN_valid/reqN_sector   sector read request (N = 0,1), held until reqN_ack
//   reqN_ack/done/err        1-cycle pulses: accepted / delivered / failed
//   rd_start/rd_sector       to sd_reader (level start, stable sector number)
//   rd_done/rd_outen/rd_outbyte  from sd_reader
//   dat_valid/dat_byte       registered byte stream for the owner
//   dat_owner                owner of current/last transfer
//   busy                     high in every state except IDLE
//   dbg_state                current FSM state encoding
//
// Handshake: a request is offered by holding reqN_valid high with a stable
// reqN_sector; it is taken in the cycle the arbiter pulses reqN_ack, after
// which the requester may drop valid. Completion is reported by exactly one
// reqN_done or reqN_err pulse per accepted request.
module sd_sector_arbiter #(
   parameter int SECTOR_BYTES = 512,
   parameter int TIMEOUT_CYC  = 2_700_000,
   parameter int MAX_RETRY    = 2
) (
   input  logic        clk27mhz,
   input  logic        reset,
   input  logic        card_ready,
   input  logic        req0_valid,
   input  logic [31:0] req0_sector,
   output logic        req0_ack,
   output logic        req0_done,
   output logic        req0_err,
   input  logic        req1_valid,
   input  logic [31:0] req1_sector,
   output logic        req1_ack,
   output logic        req1_done,
   output logic        req1_err,
   output logic        rd_start,
   output logic [31:0] rd_sector,
   input  logic        rd_done,
   input  logic        rd_outen,
   input  logic [7:0]  rd_outbyte,
   output logic        dat_valid,
   output logic [7:0]  dat_byte,
   output logic        dat_owner,
   output logic        busy,
   output logic [2:0]  dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam int BW = $clog2(SECTOR_BYTES) + 1;
   localparam int RW = $clog2(MAX_RETRY + 1) + 1;

   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BYTES_MAX = BW'(SECTOR_BYTES);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_RETRY = 3'd4,
      S_FAIL  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          owner_q, owner_d;
   logic [31:0]   rd_sector_q, rd_sector_d;
   logic          rd_start_q, rd_start_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [BW-1:0] byte_q, byte_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          done0_q, done0_d, done1_q, done1_d;
   logic          err0_q, err0_d, err1_q, err1_d;
   logic          dat_valid_q, dat_valid_d;
   logic [7:0]    dat_byte_q, dat_byte_d;

   logic          gnt;
   logic          byte_take;
   logic [BW-1:0] byte_next;

   // Bytes past a full sector are dropped; byte_next includes a byte arriving
   // in the same cycle as rd_done so the completeness test sees it.
   assign byte_take = (state_q == S_WAIT) && rd_outen && (byte_q < BYTES_MAX);
   assign byte_next = byte_q + {{(BW-1){1'b0}}, byte_take};

   // Tie goes to the port that did not win last; single requester always wins.
   assign gnt = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      rd_sector_d  = rd_sector_q;
      rd_start_d   = rd_start_q;
      retry_d      = retry_q;
      byte_d       = byte_q;
      tmo_d        = tmo_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      dat_valid_d  = 1'b0;
      dat_byte_d   = dat_byte_q;

      case (state_q)
         S_IDLE: begin
            if (card_ready && (req0_valid || req1_valid)) begin
               ack0_d       = ~gnt;
               ack1_d       = gnt;
               rd_sector_d  = gnt ? req1_sector : req0_sector;
               owner_d      = gnt;
               last_grant_d = gnt;
               retry_d      = '0;
               byte_d       = '0;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_start_d = 1'b1;
            tmo_d      = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            byte_d      = byte_next;
            dat_valid_d = byte_take;
            if (byte_take) dat_byte_d = rd_outbyte;
            // rd_done takes priority over a timeout expiring in the same cycle.
            if (rd_done) begin
               rd_start_d = 1'b0;
               state_d    = (byte_next == BYTES_MAX) ? S_DONE : S_RETRY;
            end else if (tmo_q == TMO_LAST) begin
               rd_start_d = 1'b0;
               state_d    = S_RETRY;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_RETRY: begin
            if (retry_q < RETRY_MAX) begin
               retry_d = retry_q + 1'b1;
               byte_d  = '0;
               state_d = S_ISSUE;
            end else begin
               state_d = S_FAIL;
            end
         end
         S_DONE: begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            err0_d  = ~owner_q;
            err1_d  = owner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk27mhz or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         rd_sector_q  <= '0;
         rd_start_q   <= 1'b0;
         retry_q      <= '0;
         byte_q       <= '0;
         tmo_q        <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         dat_valid_q  <= 1'b0;
         dat_byte_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         rd_sector_q  <= rd_sector_d;
         rd_start_q   <= rd_start_d;
         retry_q      <= retry_d;
         byte_q       <= byte_d;
         tmo_q        <= tmo_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         dat_valid_q  <= dat_valid_d;
         dat_byte_q   <= dat_byte_d;
      end
   end

   assign req0_ack  = ack0_q;
   assign req1_ack  = ack1_q;
   assign req0_done = done0_q;
   assign req1_done = done1_q;
   assign req0_err  = err0_q;
   assign req1_err  = err1_q;
   assign rd_start  = rd_start_q;
   assign rd_sector = rd_sector_q;
   assign dat_valid = dat_valid_q;
   assign dat_byte  = dat_byte_q;
   assign dat_owner = owner_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
module tb_sd_sector_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- main DUT (long timeout, full sectors) ----------------
   logic        card_ready = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0] req0_sector = '0, req1_sector = '0;
   logic        rd_done = 1'b0, rd_outen = 1'b0;
   logic [7:0]  rd_outbyte = '0;
   logic        req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
   logic        rd_start, dat_valid, dat_owner, busy;
   logic [31:0] rd_sector;
   logic [7:0]  dat_byte;
   logic [2:0]  dbg_state;

   sd_sector_arbiter #(.SECTOR_BYTES(512), .TIMEOUT_CYC(1000), .MAX_RETRY(2)) u_dut (
      .clk27mhz(clk), .reset(rst), .card_ready(card_ready),
      .req0_valid(req0_valid), .req0_sector(req0_sector),
      .req0_ack(req0_ack), .req0_done(req0_done), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_sector(req1_sector),
      .req1_ack(req1_ack), .req1_done(req1_done), .req1_err(req1_err),
      .rd_start(rd_start), .rd_sector(rd_sector), .rd_done(rd_done),
      .rd_outen(rd_outen), .rd_outbyte(rd_outbyte),
      .dat_valid(dat_valid), .dat_byte(dat_byte), .dat_owner(dat_owner),
      .busy(busy), .dbg_state(dbg_state)
   );

   // ---------------- timeout DUT (TIMEOUT_CYC=100) ----------------
   logic        b_card_ready = 1'b1;
   logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0;
   logic [31:0] b_req0_sector = '0, b_req1_sector = '0;
   logic        b_rd_done = 1'b0, b_rd_outen = 1'b0;
   logic [7:0]  b_rd_outbyte = '0;
   logic        b_req0_ack, b_req0_done, b_req0_err, b_req1_ack, b_req1_done, b_req1_err;
   logic        b_rd_start, b_dat_valid, b_dat_owner, b_busy;
   logic [31:0] b_rd_sector;
   logic [7:0]  b_dat_byte;
   logic [2:0]  b_dbg_state;

   sd_sector_arbiter #(.SECTOR_BYTES(512), .TIMEOUT_CYC(100), .MAX_RETRY(2)) u_dut_tmo (
      .clk27mhz(clk), .reset(rst), .card_ready(b_card_ready),
      .req0_valid(b_req0_valid), .req0_sector(b_req0_sector),
      .req0_ack(b_req0_ack), .req0_done(b_req0_done), .req0_err(b_req0_err),
      .req1_valid(b_req1_valid), .req1_sector(b_req1_sector),
      .req1_ack(b_req1_ack), .req1_done(b_req1_done), .req1_err(b_req1_err),
      .rd_start(b_rd_start), .rd_sector(b_rd_sector), .rd_done(b_rd_done),
      .rd_outen(b_rd_outen), .rd_outbyte(b_rd_outbyte),
      .dat_valid(b_dat_valid), .dat_byte(b_dat_byte), .dat_owner(b_dat_owner),
      .busy(b_busy), .dbg_state(b_dbg_state)
   );

   // ---------------- scoreboard ----------------
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   logic       exp_owner = 1'b0;
   int         rcv_cnt = 0;
   int         rise_cnt = 0;
   logic       rd_start_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dat_valid) begin
         if (exp_q.size() == 0) begin
            check("dat_unexpected", {31'b0, dat_valid}, 32'd0);
         end else begin
            logic [7:0] eb;
            eb = exp_q.pop_front();
            check("dat_byte", {24'b0, dat_byte}, {24'b0, eb});
            check("dat_owner", {31'b0, dat_owner}, {31'b0, exp_owner});
            rcv_cnt++;
         end
      end
      if (rd_start && !rd_start_prev) rise_cnt++;
      rd_start_prev = rd_start;
   end

   // ---------------- driver tasks ----------------
   task automatic wait_rd_start(input int budget);
      int k = 0;
      while (!rd_start && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("rd_start_rise", {31'b0, rd_start}, 32'd1);
   endtask

   // mode 0: rd_done after last byte; 1: rd_done with last byte; 2: no rd_done
   task automatic send_bytes(input int n, input int mode, input logic [7:0] seed);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = seed + 8'(i * 3);
         rd_outen   = 1'b1;
         rd_outbyte = b;
         rd_done    = (mode == 1) && (i == n - 1);
         exp_q.push_back(b);
         @(negedge clk);
      end
      rd_outen = 1'b0;
      rd_done  = 1'b0;
      if (mode == 0) begin
         rd_done = 1'b1;
         @(negedge clk);
         rd_done = 1'b0;
      end
   endtask

   task automatic expect_ack(input int port, input int budget);
      int k = 0;
      while (!(req0_ack || req1_ack) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("ack_seen", {31'b0, req0_ack | req1_ack}, 32'd1);
      check("ack_port", {31'b0, req1_ack}, port);
      check("ack_owner", {31'b0, dat_owner}, port);
      check("ack_rd_start_low", {31'b0, rd_start}, 32'd0);
      exp_owner = port[0];
      if (port == 0) req0_valid = 1'b0;
      else           req1_valid = 1'b0;
   endtask

   // Called at the negedge where the FSM has just left WAIT for DONE.
   task automatic finish_ok(input int port);
      check("done_rd_start_low", {31'b0, rd_start}, 32'd0);
      @(negedge clk);
      check("done0_pulse", {31'b0, req0_done}, (port == 0) ? 32'd1 : 32'd0);
      check("done1_pulse", {31'b0, req1_done}, (port == 1) ? 32'd1 : 32'd0);
      check("no_err", {30'b0, req0_err, req1_err}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {30'b0, req0_done, req1_done}, 32'd0);
   endtask

   task automatic serve_full(input logic [7:0] seed);
      wait_rd_start(4);
      send_bytes(512, 0, seed);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int r0;
      int ack_t, err_t, hi, err_n, done_n, b_ack_n;
      int lens[$];
      logic seen;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_rd_start", {31'b0, rd_start}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_state", {29'b0, dbg_state}, 32'd0);
      check("rst_pulses", {26'b0, req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err}, 32'd0);
      check("rst_dat", {22'b0, dat_valid, dat_owner, dat_byte}, 32'd0);
      check("rst_rd_sector", rd_sector, 32'd0);

      // T1: single port-0 read of sector 5
      req0_sector = 32'd5;
      req0_valid  = 1'b1;
      @(negedge clk);
      check("t1_ack0", {31'b0, req0_ack}, 32'd1);
      check("t1_sector", rd_sector, 32'd5);
      check("t1_busy", {31'b0, busy}, 32'd1);
      expect_ack(0, 1);
      @(negedge clk);
      check("t1_rd_start", {31'b0, rd_start}, 32'd1);
      send_bytes(512, 0, 8'h11);
      finish_ok(0);
      check("t1_rcv", rcv_cnt, 32'd512);

      // Reader activity while idle is ignored
      rd_outen = 1'b1;
      rd_done  = 1'b1;
      @(negedge clk);
      rd_outen = 1'b0;
      rd_done  = 1'b0;
      @(negedge clk);
      check("idle_ignore_busy", {31'b0, busy}, 32'd0);
      check("idle_ignore_dat", {31'b0, dat_valid}, 32'd0);

      // T2: round robin from reset, order 0,1,0,1
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0_sector = 32'd10; req0_valid = 1'b1;
      req1_sector = 32'd11; req1_valid = 1'b1;
      @(negedge clk);
      expect_ack(0, 3);
      check("t2_sector_a", rd_sector, 32'd10);
      serve_full(8'h20);
      finish_ok(0);
      expect_ack(1, 3);
      check("t2_sector_b", rd_sector, 32'd11);
      req0_sector = 32'd12; req0_valid = 1'b1;
      req1_sector = 32'd13; req1_valid = 1'b1;
      serve_full(8'h30);
      finish_ok(1);
      expect_ack(0, 3);
      check("t2_sector_c", rd_sector, 32'd12);
      serve_full(8'h40);
      finish_ok(0);
      expect_ack(1, 3);
      check("t2_sector_d", rd_sector, 32'd13);
      serve_full(8'h50);
      finish_ok(1);

      // T3: reader never answers (TIMEOUT_CYC=100): three 100-cycle attempts then err1
      ack_t = -1; err_t = -1; hi = 0; err_n = 0; done_n = 0; b_ack_n = 0;
      b_req1_sector = 32'd77;
      b_req1_valid  = 1'b1;
      for (int c = 1; c <= 360; c++) begin
         @(negedge clk);
         if (b_req1_ack) begin
            b_ack_n++;
            if (ack_t < 0) ack_t = c;
            b_req1_valid = 1'b0;
         end
         if (b_rd_start) hi++;
         else if (hi > 0) begin
            lens.push_back(hi);
            hi = 0;
         end
         if (b_req1_err) begin
            err_n++;
            err_t = c;
         end
         if (b_req1_done || b_req0_done || b_req0_err) done_n++;
      end
      check("t3_acks", b_ack_n, 32'd1);
      check("t3_attempts", lens.size(), 32'd3);
      foreach (lens[i]) check("t3_attempt_len", lens[i], 32'd100);
      check("t3_err_count", err_n, 32'd1);
      check("t3_no_done", done_n, 32'd0);
      check("t3_err_latency", err_t - ack_t, 32'd307);
      check("t3_sector", b_rd_sector, 32'd77);
      check("t3_idle", {31'b0, b_busy}, 32'd0);

      // T4: short read (300 bytes) then full read with rd_done on the last byte
      r0 = rise_cnt;
      req0_sector = 32'd20;
      req0_valid  = 1'b1;
      @(negedge clk);
      expect_ack(0, 3);
      wait_rd_start(4);
      send_bytes(300, 0, 8'h60);
      check("t4_retry_low", {31'b0, rd_start}, 32'd0);
      check("t4_no_err", {31'b0, req0_err}, 32'd0);
      wait_rd_start(4);
      send_bytes(512, 1, 8'h70);
      finish_ok(0);
      check("t4_attempts", rise_cnt - r0, 32'd2);

      // T5: no grant while card not ready
      card_ready  = 1'b0;
      req1_sector = 32'd99;
      req1_valid  = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | req1_ack | busy;
      end
      check("t5_no_ack", {31'b0, seen}, 32'd0);
      card_ready = 1'b1;
      @(negedge clk);
      check("t5_ack1", {31'b0, req1_ack}, 32'd1);
      expect_ack(1, 1);
      check("t5_sector", rd_sector, 32'd99);

      // T6: reset mid-transfer after 100 bytes
      wait_rd_start(4);
      send_bytes(99, 2, 8'h80);
      rd_outen   = 1'b1;
      rd_outbyte = 8'hEE;
      @(posedge clk);
      #2;
      check("t6_pre_dat_valid", {31'b0, dat_valid}, 32'd1);
      rd_outen = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_rd_start_async", {31'b0, rd_start}, 32'd0);
      check("t6_busy_async", {31'b0, busy}, 32'd0);
      check("t6_dat_valid_async", {31'b0, dat_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req1_sector = 32'd200;
      req1_valid  = 1'b1;
      @(negedge clk);
      expect_ack(1, 3);
      check("t6_sector", rd_sector, 32'd200);
      serve_full(8'h90);
      finish_ok(1);

      // Final scoreboard state
      check("sb_empty", exp_q.size(), 32'd0);
      check("sb_rcv_total", rcv_cnt, 32'd3983);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
